// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU.
// Holds the IF-stage state encoding, next-PC select codes, the NOP word,
// the datapath width and a word-alignment helper.
package cpu_pkg;

  localparam int XLEN = 32;

  // Next-PC select codes driven by the decode stage.
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  // sll $0,$0,0 encodes as all zeros.
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } if_state_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection for the fetch stage.
// Ports:
//   pc       in  32  current fetch PC
//   pcsource in  2   00 pc+4, 01 bpc, 10 rpc, 11 jpc
//   bpc      in  32  branch target
//   rpc      in  32  jr register target
//   jpc      in  32  j/jal target
//   pc4      out 32  pc+4 (modulo 2^32)
//   npc      out 32  selected target, word aligned
module pc_next_mux
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] rpc,
  input  logic [XLEN-1:0] jpc,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] npc
);

  logic [XLEN-1:0] target_s;

  // Sequential increment wraps naturally at 32 bits.
  assign pc4 = pc + 32'd4;

  // 4:1 target select.
  always_comb begin
    target_s = pc4;
    case (pcsource)
      PCSRC_SEQ: target_s = pc4;
      PCSRC_BR:  target_s = bpc;
      PCSRC_JR:  target_s = rpc;
      PCSRC_J:   target_s = jpc;
      default:   target_s = pc4;
    endcase
  end

  // Register and jump targets may carry stray low bits; drop them here.
  assign npc = word_align(target_s);

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Issues word fetches over a req/ack handshake, buffers an instruction that
// arrives while decode is stalled, and inserts bubbles while memory waits.
// Ports:
//   clk, clrn            clock, async active-low reset
//   wpcir                1 = PC and IF/ID may update, 0 = hold
//   pcsource,bpc,rpc,jpc next-PC select and targets from decode
//   imem_req/addr        fetch request and word address (= pc)
//   imem_rdata/ack       fetched word and its one-cycle completion strobe
//   pc                   current fetch PC
//   dpc4,dinst,dvalid    IF/ID register contents
module pipe_if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        dvalid
);

  if_state_t   state_r;
  if_state_t   state_next_s;
  logic [31:0] pc_r;
  logic [31:0] dpc4_r;
  logic [31:0] dinst_r;
  logic        dvalid_r;
  logic [31:0] hold_r;
  logic [31:0] pc4_s;
  logic [31:0] npc_s;

  pc_next_mux u_pc_next_mux (
    .pc       (pc_r),
    .pcsource (pcsource),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .pc4      (pc4_s),
    .npc      (npc_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BOOT: begin
        state_next_s = FETCH;
      end
      FETCH: begin
        if (imem_ack && !wpcir) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = FETCH;
        end
      end
      HOLD: begin
        if (wpcir) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = BOOT;
      end
    endcase
  end

  // FSM outputs: a request is outstanding exactly while in FETCH.
  always_comb begin
    imem_req = 1'b0;
    case (state_r)
      FETCH:   imem_req = 1'b1;
      BOOT:    imem_req = 1'b0;
      HOLD:    imem_req = 1'b0;
      default: imem_req = 1'b0;
    endcase
  end

  // PC, IF/ID register and stall buffer. A late ack in BOOT/HOLD is ignored.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_r     <= RESET_PC;
      dpc4_r   <= 32'h0000_0000;
      dinst_r  <= NOP_INST;
      dvalid_r <= 1'b0;
      hold_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_ack && wpcir) begin
            dinst_r  <= imem_rdata;
            dpc4_r   <= pc4_s;
            dvalid_r <= 1'b1;
            pc_r     <= npc_s;
          end else if (imem_ack) begin
            hold_r <= imem_rdata;
          end else if (wpcir) begin
            // Memory still busy: push a bubble, keep dpc4 as is.
            dinst_r  <= NOP_INST;
            dvalid_r <= 1'b0;
          end
        end
        HOLD: begin
          if (wpcir) begin
            dinst_r  <= hold_r;
            dpc4_r   <= pc4_s;
            dvalid_r <= 1'b1;
            pc_r     <= npc_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign dpc4      = dpc4_r;
  assign dinst     = dinst_r;
  assign dvalid    = dvalid_r;

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline; sits directly upstream of the decode stage inside the cpu top.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake that tolerates wait states.
- Selects the next PC from decode-stage redirect inputs and honours the decode-stage stall (wpcir).
- Delivers the instruction and PC+4 to decode, inserting NOP bubbles while memory is not ready.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low two bits must be 00.
NOP_INST, 32'h0000_0000, instruction word used for bubbles (sll $0,$0,0).

Ports:
clk  in  1  pipeline clock, rising edge.
clrn  in  1  asynchronous active-low reset.
wpcir  in  1  1 = PC and IF/ID may update; 0 = decode stall, hold both.
pcsource  in  2  next-PC select: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
bpc  in  32  branch target from decode.
rpc  in  32  jr register target from decode.
jpc  in  32  j/jal target from decode.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch word address; equals pc.
imem_rdata  in  32  fetched instruction; valid only when imem_ack=1.
imem_ack  in  1  one-cycle completion strobe for the current request.
pc  out  32  current fetch PC.
dpc4  out  32  IF/ID: PC+4 of the instruction in decode.
dinst  out  32  IF/ID: instruction in decode.
dvalid  out  1  IF/ID: 1 = real instruction, 0 = bubble.

Behaviour:
- Reset (clrn=0, async): pc=RESET_PC, imem_req=0, dinst=NOP_INST, dpc4=0, dvalid=0, hold buffer cleared, state=BOOT. An outstanding request is abandoned; a late imem_ack after reset is ignored in BOOT.
- States: BOOT, FETCH, HOLD.
- BOOT: imem_req=0; unconditionally go to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=pc. Address is held stable until imem_ack.
  - ack=1, wpcir=1: dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1, pc<=npc; stay in FETCH. The next request uses the new address on the following cycle, with no dead cycle, so throughput is 1 instr/cycle at zero wait.
  - ack=1, wpcir=0: capture imem_rdata into the hold buffer; IF/ID and pc unchanged; go to HOLD.
  - ack=0, wpcir=1: IF/ID loads a bubble (dinst=NOP_INST, dvalid=0, dpc4 unchanged); pc unchanged.
  - ack=0, wpcir=0: everything held.
- HOLD: imem_req=0. When wpcir=1, IF/ID loads from the buffer, dpc4<=pc+4, dvalid<=1, pc<=npc, go to FETCH. When wpcir=0, stay in HOLD.
- npc: mux on pcsource, sampled only in the cycle pc advances. Bits [1:0] are forced to 00 on every pc load.
- Decode must drive pcsource=00 while its IF/ID entry is a bubble.
- Branch delay slot is architectural: redirect never squashes the instruction already in IF/ID.
- Arithmetic: pc+4 is 32-bit modulo; 0xFFFF_FFFC wraps to 0x0000_0000.
- imem_ack outside FETCH is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - if_state_t enum (BOOT, FETCH, HOLD);
  - PCSRC_SEQ/BR/JR/J constants (2'b00..2'b11);
  - NOP word;
  - XLEN=32.
- One natural sub-module: pc_next_mux, the combinational 4:1 target mux plus alignment and pc+4 adder. The FSM and IF/ID register stay in pipe_if_stage.

Test Plan:
1. Reset: hold clrn=0 → pc=0, imem_req=0, dvalid=0, dinst=0. Release → one BOOT cycle, then imem_req=1, imem_addr=0. Assert clrn=0 mid-FETCH → outputs reset immediately, without waiting for an edge.
2. Zero-wait stream: ack every cycle, rdata=0x1000_0000|addr, wpcir=1 → imem_addr 0,4,8,C on consecutive cycles; dinst 0x10000000, 0x10000004, ...; dpc4 4, 8, C; dvalid=1 throughout.
3. Wait states: ack for addr 0x4 delayed 2 cycles → imem_addr holds 0x4, two bubbles (dvalid=0, dinst=0), then dinst=0x10000004, dpc4=0x8.
4. Stall: wpcir=0 on the ack cycle for addr 0x8 → HOLD, imem_req=0, IF/ID unchanged for 3 cycles. wpcir=1 → dinst=0x10000008, pc=0xC, request to 0xC the next cycle.
5. Redirects:
   - pcsource=01, bpc=0x100 on the advancing cycle → next imem_addr=0x100.
   - pcsource=11, jpc=0x203 → 0x200.
   - pcsource=10, rpc=0x40 → 0x40.
   - The instruction already in IF/ID stays valid (delay slot).
6. Wrap: RESET_PC=0xFFFF_FFFC, ack with pcsource=00 → dpc4=0, next imem_addr=0x0000_0000.
